mem_bus_arbiter: RTL and testbench

- N-channel arbiter for one shared external asynchronous memory pin bus: 16-bit data, common OE/WE/address lines, with PSRAM, PCM and flash controllers on the same pins.
- Each channel controller keeps its own wishbone slave. This block gates each controller's cyc/stb through `en` and muxes the owning controller's pin signals onto the board pins.
- Supersedes the fixed two-device RAM/PCM mux with:
  - parametrised channel count and widths;
  - round-robin or fixed priority;
  - sticky grants for bursts;
  - starvation limit;
  - bus-conflict detection.

---
 rtl/mem_bus_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// N-channel arbiter sharing one asynchronous memory pin bus between several controllers.
// Optional per-channel grant/starvation statistics are built when MEM_ARB_STATS_EN is defined.
module mem_bus_arbiter #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned ID_BITS       = 2,
  parameter int unsigned ADDR_BITS     = 24,
  parameter int unsigned DATA_BITS     = 16,
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned MAX_HOLD      = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CHANNELS-1:0]               req,
  input  logic [CHANNELS-1:0]               busy,
  output logic [CHANNELS-1:0]               en,
  output logic [ID_BITS-1:0]                owner,
  output logic                              working,
  output logic                              conflict,
  input  logic [CHANNELS-1:0]               ch_oe_n,
  input  logic [CHANNELS-1:0]               ch_we_n,
  input  logic [CHANNELS*(ADDR_BITS-1)-1:0] ch_addr,
  input  logic [CHANNELS*DATA_BITS-1:0]     ch_dout,
  output logic [CHANNELS*DATA_BITS-1:0]     ch_din,
  output logic                              mem_oe_n,
  output logic                              mem_we_n,
  output logic [ADDR_BITS-2:0]              mem_addr,
  inout  wire  [DATA_BITS-1:0]              mem_data
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic [ID_BITS-1:0]                stat_sel,
  input  logic                              stat_clr,
  output logic [31:0]                       stat_data
`endif
);

  localparam int unsigned AW        = ADDR_BITS - 1;
  localparam int unsigned HOLD_BITS = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_BITS-1:0] HOLD_MAX = HOLD_BITS'(MAX_HOLD);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e                r_state;
  logic [ID_BITS-1:0]    r_owner;
  logic [HOLD_BITS-1:0]  r_hold;
  logic                  r_conflict;

  logic [CHANNELS-1:0]   w_owner_oh;
  logic [CHANNELS-1:0]   w_others;
  logic [ID_BITS-1:0]    w_pick;
  logic [ID_BITS-1:0]    w_pick_oth;
  logic                  w_pick_valid;
  logic                  w_quiet;
  logic                  w_working;
  logic                  w_release;
  logic                  w_preempt;
  logic                  w_conf;
  logic                  w_drive;
  logic                  w_own_oe_n;
  logic                  w_own_we_n;
  logic [AW-1:0]         w_own_addr;
  logic [DATA_BITS-1:0]  w_own_dout;
  logic [DATA_BITS-1:0]  w_dout;

  // Round-robin searches base+1 .. base with wrap; fixed mode scans from index 0.
  function automatic logic [ID_BITS-1:0] f_pick(input logic [CHANNELS-1:0] mask,
                                                input logic [ID_BITS-1:0]  base);
    logic [ID_BITS-1:0]  sel;
    logic [CHANNELS-1:0] sh;
    logic                found;
    int                  idx;
    sel   = base;
    found = 1'b0;
    for (int k = 1; k <= int'(CHANNELS); k++) begin
      if (PRIORITY_MODE != 0) idx = k - 1;
      else                    idx = (int'(base) + k) % int'(CHANNELS);
      sh = mask >> idx;
      if (!found && sh[0]) begin
        sel   = ID_BITS'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    w_owner_oh   = CHANNELS'(1) << r_owner;
    w_others     = req & ~w_owner_oh;
    w_pick_valid = |req;
    w_pick       = f_pick(req, r_owner);
    w_pick_oth   = f_pick(w_others, r_owner);
    w_quiet      = (busy == '0);
    w_working    = (r_state == StGrant);
    w_release    = ((req & w_owner_oh) == '0) && w_quiet;
    w_preempt    = (MAX_HOLD != 0) && (r_hold == HOLD_MAX) && (|w_others) && w_quiet;
    w_conf       = (|(busy & ~w_owner_oh)) || ($countones(busy) > 1) || (!w_working && |busy);
  end

  always_comb begin
    en = '0;
    if (w_working)         en = w_owner_oh;
    else if (w_pick_valid) en = CHANNELS'(1) << w_pick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_owner    <= '0;
      r_hold     <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_conf) r_conflict <= 1'b1;
      unique case (r_state)
        StIdle: begin
          r_hold <= '0;
          if (w_pick_valid && w_quiet) begin
            r_owner <= w_pick;
            r_state <= StGrant;
          end
        end
        StGrant: begin
          if (w_release) begin
            r_state <= StIdle;
            r_hold  <= '0;
          end else if (w_preempt) begin
            r_owner <= w_pick_oth;
            r_hold  <= '0;
          end else if ((|w_others) && (r_hold != HOLD_MAX)) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign owner    = r_owner;
  assign working  = w_working;
  assign conflict = r_conflict;

  always_comb begin
    w_own_oe_n = 1'b1;
    w_own_we_n = 1'b1;
    w_own_addr = '0;
    w_own_dout = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (ID_BITS'(i) == r_owner) begin
        w_own_oe_n = ch_oe_n[i];
        w_own_we_n = ch_we_n[i];
        w_own_addr = ch_addr[i*AW +: AW];
        w_own_dout = ch_dout[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Pins follow the owner only while it is actually driving the bus.
  always_comb begin
    w_drive  = w_working && (|(busy & w_owner_oh));
    mem_oe_n = w_drive ? w_own_oe_n : 1'b1;
    mem_we_n = w_drive ? w_own_we_n : 1'b1;
    mem_addr = w_drive ? w_own_addr : '0;
    w_dout   = w_drive ? w_own_dout : '0;
  end

  assign mem_data = mem_oe_n ? w_dout : 'z;

  always_comb begin
    ch_din = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if ((ID_BITS'(i) == r_owner) && busy[i] && !ch_oe_n[i]) begin
        ch_din[i*DATA_BITS +: DATA_BITS] = mem_data;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0]        r_grants [CHANNELS];
  logic [15:0]        r_starve [CHANNELS];
  logic               w_grant_go;
  logic [ID_BITS-1:0] w_grant_id;
  logic [31:0]        w_stat_sel;

  always_comb begin
    w_grant_go = 1'b0;
    w_grant_id = w_pick;
    if (!w_working) begin
      w_grant_go = w_pick_valid && w_quiet;
    end else if (!w_release && w_preempt) begin
      w_grant_go = 1'b1;
      w_grant_id = w_pick_oth;
    end
    w_stat_sel = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (ID_BITS'(i) == stat_sel) w_stat_sel = {r_grants[i], r_starve[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        r_grants[i] <= '0;
        r_starve[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (w_grant_go && (w_grant_id == ID_BITS'(i)) && (r_grants[i] != 16'hFFFF)) begin
          r_grants[i] <= r_grants[i] + 16'd1;
        end
        if (req[i] && !(w_working && (r_owner == ID_BITS'(i))) && (r_starve[i] != 16'hFFFF)) begin
          r_starve[i] <= r_starve[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stat_data <= '0;
    else     stat_data <= w_stat_sel;
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: round-robin and fixed-priority instances,
// expected owners queued when requests are driven and compared when grants appear.
module tb_mem_bus_arbiter;
  localparam int CH = 4;
  localparam int AW = 23;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [CH-1:0]    req, busy, ch_oe_n, ch_we_n;
  logic [CH*AW-1:0] ch_addr;
  logic [CH*DW-1:0] ch_dout;
  logic [CH-1:0]    en;
  logic [1:0]       owner;
  logic             working, conflict;
  logic [CH*DW-1:0] ch_din;
  logic             mem_oe_n, mem_we_n;
  logic [AW-1:0]    mem_addr;
  wire  [DW-1:0]    mem_data;
  logic [DW-1:0]    rd_data;

  logic [CH-1:0]    f_req, f_busy, f_en;
  logic [1:0]       f_owner;
  logic             f_working, f_conflict, f_oe_n, f_we_n;
  logic [CH*DW-1:0] f_ch_din;
  logic [AW-1:0]    f_addr;
  wire  [DW-1:0]    f_mem_data;

  // External memory drives the pins only while output enable is asserted.
  assign mem_data = (mem_oe_n == 1'b0) ? rd_data : 'z;

  mem_bus_arbiter u_rr (
    .clk(clk), .rst(rst), .req(req), .busy(busy), .en(en), .owner(owner),
    .working(working), .conflict(conflict), .ch_oe_n(ch_oe_n), .ch_we_n(ch_we_n),
    .ch_addr(ch_addr), .ch_dout(ch_dout), .ch_din(ch_din), .mem_oe_n(mem_oe_n),
    .mem_we_n(mem_we_n), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  mem_bus_arbiter #(.PRIORITY_MODE(1)) u_fix (
    .clk(clk), .rst(rst), .req(f_req), .busy(f_busy), .en(f_en), .owner(f_owner),
    .working(f_working), .conflict(f_conflict), .ch_oe_n(ch_oe_n), .ch_we_n(ch_we_n),
    .ch_addr(ch_addr), .ch_dout(ch_dout), .ch_din(f_ch_din), .mem_oe_n(f_oe_n),
    .mem_we_n(f_we_n), .mem_addr(f_addr), .mem_data(f_mem_data)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [63:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [63:0] obs);
    if (sb_q.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL %s: got %0h want <empty scoreboard>", tag, obs);
    end else begin
      chk(tag, obs, sb_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(32'h0A0000 + 32'(i) * 32'h1111);
  endfunction

  function automatic logic [DW-1:0] dout_of(input int i);
    return DW'(32'hD000 + 32'(i));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_own;
    logic [3:0] oh;
    rst = 1'b1; req = '0; busy = '0; f_req = '0; f_busy = '0;
    ch_oe_n = '1; ch_we_n = '1; rd_data = '0;
    for (int i = 0; i < CH; i++) begin
      ch_addr[i*AW +: AW] = addr_of(i);
      ch_dout[i*DW +: DW] = dout_of(i);
    end
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_working", 64'(working), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_en", 64'(en), 64'd0);
    chk("rst_oe_n", 64'(mem_oe_n), 64'd1);
    chk("rst_we_n", 64'(mem_we_n), 64'd1);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_data", 64'(mem_data), 64'd0);
    chk("rst_conflict", 64'(conflict), 64'd0);

    // Round-robin: every channel requesting, one 3-cycle write burst each.
    exp_own = 2'd0;
    for (int b = 0; b < 4; b++) begin
      req = 4'b1111;
      exp_own = 2'(exp_own + 2'd1);
      oh = 4'b0001 << exp_own;
      sb_q.push_back(64'(exp_own));
      #1;
      chk("rr_lookahead_en", 64'(en), 64'(oh));
      tick();
      chk("rr_working", 64'(working), 64'd1);
      sb_check("rr_owner", 64'(owner));
      busy = oh;
      ch_we_n = ~oh;
      #1;
      chk("rr_addr", 64'(mem_addr), 64'(addr_of(int'(exp_own))));
      chk("rr_we_n", 64'(mem_we_n), 64'd0);
      chk("rr_wdata", 64'(mem_data), 64'(dout_of(int'(exp_own))));
      tick(); tick(); tick();
      chk("rr_burst_owner", 64'(owner), 64'(exp_own));
      busy = '0;
      ch_we_n = '1;
      req = 4'b1111 & ~oh;
      tick();
      chk("rr_release", 64'(working), 64'd0);
    end

    // Read through owner 2.
    req = 4'b0100;
    sb_q.push_back(64'd2);
    tick();
    sb_check("rd_owner", 64'(owner));
    busy = 4'b0100;
    ch_oe_n = 4'b1011;
    rd_data = 16'hA5C3;
    #1;
    chk("rd_oe_n", 64'(mem_oe_n), 64'd0);
    chk("rd_din", 64'(ch_din), 64'h0000_A5C3_0000_0000);
    tick();
    busy = '0; ch_oe_n = '1; req = '0;
    tick();
    chk("rd_release", 64'(working), 64'd0);

    // Conflict: channel 3 drives while channel 0 owns the bus.
    req = 4'b0001;
    sb_q.push_back(64'd0);
    tick();
    sb_check("cf_owner", 64'(owner));
    busy = 4'b1001;
    #1;
    chk("cf_before", 64'(conflict), 64'd0);
    tick();
    chk("cf_set", 64'(conflict), 64'd1);
    chk("cf_addr", 64'(mem_addr), 64'(addr_of(0)));
    busy = 4'b0001;
    tick();
    chk("cf_sticky", 64'(conflict), 64'd1);
    busy = '0; req = '0;
    tick();
    chk("cf_sticky_idle", 64'(conflict), 64'd1);

    // Reset in the middle of a burst from channel 1.
    req = 4'b0010;
    sb_q.push_back(64'd1);
    tick();
    sb_check("mr_owner", 64'(owner));
    busy = 4'b0010;
    #1;
    chk("mr_addr_live", 64'(mem_addr), 64'(addr_of(1)));
    rst = 1'b1; req = '0;
    tick();
    chk("mr_working", 64'(working), 64'd0);
    chk("mr_en", 64'(en), 64'd0);
    chk("mr_oe_n", 64'(mem_oe_n), 64'd1);
    chk("mr_we_n", 64'(mem_we_n), 64'd1);
    chk("mr_addr", 64'(mem_addr), 64'd0);
    chk("mr_data", 64'(mem_data), 64'd0);
    chk("mr_conflict", 64'(conflict), 64'd0);
    rst = 1'b0; busy = '0;
    tick();

    // Fixed priority with channels 1 and 2 contending.
    f_req = 4'b0110;
    #1;
    chk("fx_lookahead_en", 64'(f_en), 64'b0010);
    sb_q.push_back(64'd1);
    tick();
    sb_check("fx_first", 64'(f_owner));
    repeat (64) tick();
    chk("fx_hold_full", 64'(f_owner), 64'd1);
    sb_q.push_back(64'd2);
    tick();
    sb_check("fx_preempt", 64'(f_owner));
    repeat (64) tick();
    f_busy = 4'b0100;
    repeat (3) tick();
    chk("fx_busy_blocks", 64'(f_owner), 64'd2);
    f_busy = '0;
    sb_q.push_back(64'd1);
    tick();
    sb_check("fx_back", 64'(f_owner));
    chk("fx_conflict", 64'(f_conflict), 64'd0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
